if_prefetch_queue: RTL and testbench

//  Parametrised instruction prefetch queue; replaces single-request IF. Owns fetch PC, keeps up to
//  MAX_OUT icache requests in flight, buffers DEPTH instr/PC pairs, issues in order via valid/ready.

---
 rtl/if_prefetch_queue.sv | 124 ++++++++++++
 tb/tb_if_prefetch_queue.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, keeps several icache requests
// in flight and hands buffered instr/PC pairs to issue in program order.
module if_prefetch_queue #(
    parameter int                DEPTH    = 8,
    parameter int                MAX_OUT  = 2,
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       rdy_in,
    input  logic                       redirect_en_in,
    input  logic [ADDR_W-1:0]          redirect_pc_in,
    output logic                       ic_req_out,
    output logic [ADDR_W-1:0]          ic_addr_out,
    input  logic                       ic_gnt_in,
    input  logic                       ic_resp_in,
    input  logic [INSTR_W-1:0]         ic_data_in,
    output logic                       issue_valid_out,
    input  logic                       issue_ready_in,
    output logic [INSTR_W-1:0]         instr_out,
    output logic [ADDR_W-1:0]          pc_out,
    output logic [$clog2(DEPTH):0]     count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   MAX_C   = (CW + 1)'(MAX_OUT);

    logic [ADDR_W-1:0]  fetch_pc;
    logic [PW-1:0]      head;
    logic [PW-1:0]      alloc;
    logic [PW-1:0]      fill;
    logic [CW-1:0]      alloc_cnt;
    logic [CW-1:0]      fill_cnt;
    logic [CW-1:0]      out_cnt;
    logic [CW-1:0]      drop_cnt;
    logic [ADDR_W-1:0]  pc_q    [DEPTH];
    logic [INSTR_W-1:0] instr_q [DEPTH];

    logic [CW:0] inflight;
    logic        redirect;
    logic        accept;
    logic        resp;
    logic        resp_drop;
    logic        resp_fill;
    logic        issue;

    // Credit covers both live and to-be-dropped requests, so the slot
    // reserved at request time is always there when the response lands.
    assign inflight  = {1'b0, out_cnt} + {1'b0, drop_cnt};
    assign ic_req_out = rst_n_in & rdy_in & ~redirect_en_in
                      & (alloc_cnt < DEPTH_C) & (inflight < MAX_C);

    assign redirect  = rdy_in & redirect_en_in;
    assign accept    = ic_req_out & ic_gnt_in;
    assign resp      = rdy_in & ic_resp_in;
    assign resp_drop = resp & (drop_cnt != '0);
    assign resp_fill = resp & (drop_cnt == '0) & ~redirect;
    assign issue     = rdy_in & ~redirect & issue_valid_out & issue_ready_in;

    assign ic_addr_out     = fetch_pc;
    assign issue_valid_out = (fill_cnt != '0);
    assign instr_out       = instr_q[head];
    assign pc_out          = pc_q[head];
    assign count_out       = fill_cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fetch_pc  <= RESET_PC;
            head      <= '0;
            alloc     <= '0;
            fill      <= '0;
            alloc_cnt <= '0;
            fill_cnt  <= '0;
            out_cnt   <= '0;
            drop_cnt  <= '0;
        end else if (redirect) begin
            fetch_pc  <= redirect_pc_in;
            head      <= '0;
            alloc     <= '0;
            fill      <= '0;
            alloc_cnt <= '0;
            fill_cnt  <= '0;
            out_cnt   <= '0;
            // a response arriving with the redirect is already stale
            drop_cnt  <= drop_cnt + out_cnt - CW'(resp);
        end else begin
            if (accept) begin
                alloc    <= alloc + PW'(1);
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            if (resp_fill) begin
                fill <= fill + PW'(1);
            end
            if (issue) begin
                head <= head + PW'(1);
            end
            if (resp_drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            alloc_cnt <= alloc_cnt + CW'(accept) - CW'(issue);
            fill_cnt  <= fill_cnt + CW'(resp_fill) - CW'(issue);
            out_cnt   <= out_cnt + CW'(accept) - CW'(resp_fill);
        end
    end

    always_ff @(posedge clk_in) begin
        if (accept) begin
            pc_q[alloc] <= fetch_pc;
        end
        if (resp_fill) begin
            instr_q[fill] <= ic_data_in;
        end
    end

    resp_has_owner: assert property (
        @(posedge clk_in) disable iff (!rst_n_in)
        (rdy_in && ic_resp_in) |-> (out_cnt != '0 || drop_cnt != '0)
    );

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_if_prefetch_queue;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        redirect_en_in;
    logic [31:0] redirect_pc_in;
    logic        ic_req_out;
    logic [31:0] ic_addr_out;
    logic        ic_gnt_in;
    logic        ic_resp_in;
    logic [31:0] ic_data_in;
    logic        issue_valid_out;
    logic        issue_ready_in;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [3:0]  count_out;

    if_prefetch_queue dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .rdy_in          (rdy_in),
        .redirect_en_in  (redirect_en_in),
        .redirect_pc_in  (redirect_pc_in),
        .ic_req_out      (ic_req_out),
        .ic_addr_out     (ic_addr_out),
        .ic_gnt_in       (ic_gnt_in),
        .ic_resp_in      (ic_resp_in),
        .ic_data_in      (ic_data_in),
        .issue_valid_out (issue_valid_out),
        .issue_ready_in  (issue_ready_in),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .count_out       (count_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // reference model: allocated PCs and filled instructions, in order
    logic [31:0] m_pc;
    int          m_out;
    int          m_drop;
    logic [31:0] pcq[$];
    logic [31:0] iq[$];

    logic        s_req;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [31:0] s_instr;
    logic [31:0] s_cnt;

    typedef struct {
        logic        rdy;
        logic        red;
        logic [31:0] rpc;
        logic        gnt;
        logic        resp;
        logic [31:0] data;
        logic        ir;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic can_resp();
        return (m_out + m_drop) > 0;
    endfunction

    task automatic model_reset();
        m_pc   = 32'h0;
        m_out  = 0;
        m_drop = 0;
        pcq.delete();
        iq.delete();
    endtask

    task automatic drive_idle();
        rdy_in         = 1'b0;
        redirect_en_in = 1'b0;
        redirect_pc_in = 32'h0;
        ic_gnt_in      = 1'b0;
        ic_resp_in     = 1'b0;
        ic_data_in     = 32'h0;
        issue_ready_in = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rdy_in   = 1'b1;
        rst_n_in = 1'b0;
        #1;
        chk("rst_req", 32'(ic_req_out), 32'h0);
        chk("rst_valid", 32'(issue_valid_out), 32'h0);
        chk("rst_cnt", 32'(count_out), 32'h0);
        chk("rst_addr", ic_addr_out, 32'h0);
        rdy_in = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        model_reset();
    endtask

    task automatic step(input logic rdy, input logic red,
                        input logic [31:0] rpc, input logic gnt,
                        input logic resp, input logic [31:0] data,
                        input logic ir);
        logic e_req;
        logic e_valid;
        @(negedge clk_in);
        rdy_in         = rdy;
        redirect_en_in = red;
        redirect_pc_in = rpc;
        ic_gnt_in      = gnt;
        ic_resp_in     = resp;
        ic_data_in     = data;
        issue_ready_in = ir;
        #1;
        e_req   = rdy && !red && pcq.size() < 8 && (m_out + m_drop) < 2;
        e_valid = iq.size() > 0;
        chk("ic_req", 32'(ic_req_out), 32'(e_req));
        chk("ic_addr", ic_addr_out, m_pc);
        chk("issue_valid", 32'(issue_valid_out), 32'(e_valid));
        chk("count", 32'(count_out), 32'(iq.size()));
        if (e_valid) begin
            chk("pc_out", pc_out, pcq[0]);
            chk("instr_out", instr_out, iq[0]);
        end
        s_req   = ic_req_out;
        s_valid = issue_valid_out;
        s_addr  = ic_addr_out;
        s_pc    = pc_out;
        s_instr = instr_out;
        s_cnt   = 32'(count_out);
        @(posedge clk_in);
        if (rdy) begin
            if (red) begin
                m_drop = m_drop + m_out - (resp ? 1 : 0);
                m_out  = 0;
                pcq.delete();
                iq.delete();
                m_pc = rpc;
            end else begin
                if (e_valid && ir) begin
                    void'(pcq.pop_front());
                    void'(iq.pop_front());
                end
                if (resp) begin
                    if (m_drop > 0) begin
                        m_drop--;
                    end else begin
                        iq.push_back(data);
                        m_out--;
                    end
                end
                if (e_req && gnt) begin
                    pcq.push_back(m_pc);
                    m_out++;
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic idle_step(input logic ir);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, ir);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int nr;
        logic        snap_valid;
        logic [31:0] snap_addr;
        logic [31:0] snap_pc;
        logic [31:0] snap_instr;
        logic [31:0] snap_cnt;

        tbl[0] = '{1, 0, 0, 1, 0, 32'h0,        1, 1, 32'h00, 0, 32'h0, 32'h0,        0};
        tbl[1] = '{1, 0, 0, 1, 1, 32'hA000_0000, 1, 1, 32'h04, 0, 32'h0, 32'h0,        0};
        tbl[2] = '{1, 0, 0, 1, 1, 32'hA000_0001, 1, 1, 32'h08, 1, 32'h0, 32'hA000_0000, 1};
        tbl[3] = '{1, 0, 0, 1, 1, 32'hA000_0002, 1, 1, 32'h0C, 1, 32'h4, 32'hA000_0001, 1};
        tbl[4] = '{1, 0, 0, 0, 1, 32'hA000_0003, 1, 1, 32'h10, 1, 32'h8, 32'hA000_0002, 1};
        tbl[5] = '{1, 0, 0, 0, 0, 32'h0,        0, 1, 32'h10, 1, 32'hC, 32'hA000_0003, 1};
        tbl[6] = '{1, 0, 0, 0, 0, 32'h0,        1, 1, 32'h10, 1, 32'hC, 32'hA000_0003, 1};
        tbl[7] = '{1, 0, 0, 0, 0, 32'h0,        1, 1, 32'h10, 0, 32'h0, 32'h0,        0};

        do_reset();

        // streaming fetch from reset
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].rdy, tbl[i].red, tbl[i].rpc, tbl[i].gnt,
                 tbl[i].resp, tbl[i].data, tbl[i].ir);
            chk("tbl_req", 32'(s_req), 32'(tbl[i].e_req));
            chk("tbl_addr", s_addr, tbl[i].e_addr);
            chk("tbl_valid", 32'(s_valid), 32'(tbl[i].e_valid));
            chk("tbl_cnt", s_cnt, tbl[i].e_cnt);
            if (tbl[i].e_valid) begin
                chk("tbl_pc", s_pc, tbl[i].e_pc);
                chk("tbl_instr", s_instr, tbl[i].e_instr);
            end
        end

        // issue stalled: queue fills to DEPTH and stops requesting
        do_reset();
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, can_resp(),
                 32'hB000_0000 + 32'(i), 1'b0);
            if (s_req) acc++;
        end
        chk("full_accepts", 32'(acc), 32'd8);
        chk("full_cnt", s_cnt, 32'd8);
        chk("full_req", 32'(s_req), 32'h0);
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, can_resp(),
                 32'hB100_0000 + 32'(i), 1'b1);
        end

        // redirect with two requests in flight
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0);
        nr = 0;
        s_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (can_resp()) begin
                step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hD0 + 32'(nr), 1'b0);
                nr++;
            end else begin
                step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
            end
            if (s_valid) break;
        end
        if (!s_valid) begin
            chk("redir_timeout", 32'(s_valid), 32'h1);
        end else begin
            chk("redir_pc", s_pc, 32'h100);
            chk("redir_instr", s_instr, 32'hD2);
        end

        // redirect coinciding with response and issue
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hE0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 32'hE1, 1'b1);
        idle_step(1'b0);
        chk("rc_cnt", s_cnt, 32'h0);
        chk("rc_valid", 32'(s_valid), 32'h0);
        chk("rc_req", 32'(s_req), 32'h1);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hE2, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hE3, 1'b0);
        idle_step(1'b0);
        chk("rc_pc", s_pc, 32'h200);
        chk("rc_instr", s_instr, 32'hE3);

        // fetch PC wrap, then rdy_in low freezes everything
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hF0, 1'b0);
        idle_step(1'b0);
        chk("wrap_addr", s_addr, 32'h0);
        chk("wrap_pc", s_pc, 32'hFFFF_FFFC);
        snap_valid = s_valid;
        snap_addr  = s_addr;
        snap_pc    = s_pc;
        snap_instr = s_instr;
        snap_cnt   = s_cnt;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'(i % 2), $urandom, 1'b0, 1'b0, $urandom, 1'b1);
            chk("frz_req", 32'(s_req), 32'h0);
            chk("frz_addr", s_addr, snap_addr);
            chk("frz_valid", 32'(s_valid), 32'(snap_valid));
            chk("frz_pc", s_pc, snap_pc);
            chk("frz_instr", s_instr, snap_instr);
            chk("frz_cnt", s_cnt, snap_cnt);
        end
        idle_step(1'b1);

        // async reset between clock edges in the middle of a burst
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, can_resp(), 32'hC0 + 32'(i), 1'b0);
        end
        @(negedge clk_in);
        ic_gnt_in  = 1'b0;
        ic_resp_in = 1'b0;
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("arst_req", 32'(ic_req_out), 32'h0);
        chk("arst_valid", 32'(issue_valid_out), 32'h0);
        chk("arst_cnt", 32'(count_out), 32'h0);
        chk("arst_addr", ic_addr_out, 32'h0);
        drive_idle();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        model_reset();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic rdy;
            logic red;
            rdy = ($urandom_range(0, 9) != 0);
            red = rdy && ($urandom_range(0, 19) == 0);
            step(rdy, red, $urandom & 32'hFFFF_FFFC,
                 rdy && ($urandom_range(0, 9) < 7),
                 rdy && can_resp() && ($urandom_range(0, 9) < 6),
                 $urandom, ($urandom_range(0, 9) < 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
